if_stage: RTL and testbench

IF_STAGE -- requirements
Module: if_stage

---
 rtl/if_stage_pkg.sv | 26 ++
 rtl/if_stage_pc_reg.sv | 32 +++
 rtl/if_stage.sv | 110 +++++++++++
 tb/tb_if_stage.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/if_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : if_stage_pkg
//  Purpose  : Shared CPU constants, fetch FSM state type and PC helper.
//  Revision : 1.0  initial release
// ============================================================================
package if_stage_pkg;

   localparam int unsigned WORD_W = 32;

   localparam logic [WORD_W-1:0] RESET_PC_DEFAULT  = 32'h0000_0000;
   localparam logic [WORD_W-1:0] NOP_INSTR_DEFAULT = 32'h0000_0000;

   // RUN: normal fetch. REDIR_PEND: a redirect arrived under stall and waits.
   typedef enum logic [0:0] {
      RUN        = 1'b0,
      REDIR_PEND = 1'b1
   } fetch_state_t;

   // Instruction addresses are word aligned; drop the two byte-offset bits.
   function automatic logic [WORD_W-1:0] align_pc(input logic [WORD_W-1:0] a);
      return {a[WORD_W-1:2], 2'b00};
   endfunction

endpackage
`default_nettype wire

// File: rtl/if_stage_pc_reg.sv
`default_nettype none
// ============================================================================
//  Module   : pc_reg
//  Purpose  : Program counter with load, hold and +4 increment (mod 2^32).
//  Revision : 1.0  initial release
// ============================================================================
module pc_reg
   import if_stage_pkg::*;
#(
   parameter logic [WORD_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              hold,
   input  logic              load,
   input  logic [WORD_W-1:0] load_pc,
   output logic [WORD_W-1:0] pc
);

   // Load beats hold; otherwise step to the next sequential word.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pc <= RESET_PC;
      end else if (load) begin
         pc <= load_pc;
      end else if (!hold) begin
         pc <= pc + WORD_W'(4);
      end
   end

endmodule
`default_nettype wire

// File: rtl/if_stage.sv
`default_nettype none
// ============================================================================
//  Module   : if_stage
//  Purpose  : Instruction fetch stage: PC, IF/ID pipeline register and a
//             redirect-pending FSM that defers branch targets across stalls.
//  Revision : 1.0  initial release
// ============================================================================
module if_stage
   import if_stage_pkg::*;
#(
   parameter logic [WORD_W-1:0] RESET_PC  = RESET_PC_DEFAULT,
   parameter logic [WORD_W-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              stall,
   input  logic              flush,
   input  logic              redirect,
   input  logic [WORD_W-1:0] redirect_pc,
   output logic [WORD_W-1:0] imem_addr,
   input  logic [WORD_W-1:0] imem_instr,
   output logic [WORD_W-1:0] ifid_instr,
   output logic [WORD_W-1:0] ifid_pc4,
   output logic              ifid_valid
);

   fetch_state_t      state;
   logic [WORD_W-1:0] pend_pc;
   logic [WORD_W-1:0] pc;
   logic [WORD_W-1:0] pc_plus4;
   logic [WORD_W-1:0] redir_aligned;
   logic              pc_load;
   logic [WORD_W-1:0] load_pc;
   logic              bubble;

   assign redir_aligned = align_pc(redirect_pc);
   assign pc_plus4      = pc + WORD_W'(4);
   // Fetch address comes straight from the PC flop; imem_instr never feeds it.
   assign imem_addr     = pc;

   // A fresh redirect outranks a stored one (latest target wins); both wait
   // for stall to drop before touching the PC.
   always_comb begin
      pc_load = 1'b0;
      load_pc = redir_aligned;
      if (!stall) begin
         if (redirect) begin
            pc_load = 1'b1;
            load_pc = redir_aligned;
         end else if (state == REDIR_PEND) begin
            pc_load = 1'b1;
            load_pc = pend_pc;
         end
      end
   end

   // Squash IF/ID on flush (even under stall) or whenever the PC is redirected.
   assign bubble = flush | (~stall & (redirect | (state == REDIR_PEND)));

   pc_reg #(
      .RESET_PC (RESET_PC)
   ) u_pc_reg (
      .clk     (clk),
      .rst_n   (rst_n),
      .hold    (stall),
      .load    (pc_load),
      .load_pc (load_pc),
      .pc      (pc)
   );

   // Redirect FSM plus IF/ID register; reset discards any pending target.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= RUN;
         pend_pc    <= '0;
         ifid_instr <= NOP_INSTR;
         ifid_pc4   <= '0;
         ifid_valid <= 1'b0;
      end else begin
         case (state)
            RUN: begin
               if (redirect && stall) begin
                  state   <= REDIR_PEND;
                  pend_pc <= redir_aligned;
               end
            end
            REDIR_PEND: begin
               if (!stall) begin
                  state <= RUN;
               end else if (redirect) begin
                  pend_pc <= redir_aligned;
               end
            end
            default: state <= RUN;
         endcase

         if (bubble) begin
            ifid_instr <= NOP_INSTR;
            ifid_pc4   <= '0;
            ifid_valid <= 1'b0;
         end else if (!stall) begin
            ifid_instr <= imem_instr;
            ifid_pc4   <= pc_plus4;
            ifid_valid <= 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_if_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_if_stage
//  Purpose  : Self-checking bench for if_stage (vector table + scoreboard).
//  Revision : 1.0  initial release
// ============================================================================
module tb_if_stage;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk;
   logic        rst_n;
   logic        stall;
   logic        flush;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic [31:0] imem_addr;
   logic [31:0] imem_instr;
   logic [31:0] ifid_instr;
   logic [31:0] ifid_pc4;
   logic        ifid_valid;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic        rst_n;
      logic        stall;
      logic        flush;
      logic        redirect;
      logic [31:0] rpc;
      logic [31:0] addr;
      logic [31:0] instr;
      logic [31:0] pc4;
      logic        valid;
   } vec_t;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] instr;
      logic [31:0] pc4;
      logic        valid;
      int          id;
   } exp_t;

   exp_t sb[$];

   // Instruction memory model: word content derived from its address.
   function automatic logic [31:0] mem(input logic [31:0] a);
      return a ^ 32'hA5A5_0000;
   endfunction

   assign imem_instr = mem(imem_addr);

   if_stage #(
      .RESET_PC  (32'h0000_0000),
      .NOP_INSTR (NOP)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .stall       (stall),
      .flush       (flush),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .imem_addr   (imem_addr),
      .imem_instr  (imem_instr),
      .ifid_instr  (ifid_instr),
      .ifid_pc4    (ifid_pc4),
      .ifid_valid  (ifid_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic vec_t mk(input logic r, input logic s, input logic f,
                               input logic rd, input logic [31:0] rpc,
                               input logic [31:0] a, input logic [31:0] i,
                               input logic [31:0] p4, input logic v);
      vec_t t;
      t.rst_n = r; t.stall = s; t.flush = f; t.redirect = rd; t.rpc = rpc;
      t.addr = a; t.instr = i; t.pc4 = p4; t.valid = v;
      return t;
   endfunction

   task automatic chk32(input string nm, input int id, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s step %0d: got %h expected %h", nm, id, act, req);
      end
   endtask

   // Drive one cycle, queue the expectation, then compare after the edge.
   task automatic run(input vec_t v, input int id);
      exp_t e;
      exp_t g;
      rst_n = v.rst_n; stall = v.stall; flush = v.flush;
      redirect = v.redirect; redirect_pc = v.rpc;
      e.addr = v.addr; e.instr = v.instr; e.pc4 = v.pc4; e.valid = v.valid; e.id = id;
      sb.push_back(e);
      @(posedge clk);
      #1;
      g = sb.pop_front();
      chk32("imem_addr",  g.id, imem_addr,  g.addr);
      chk32("ifid_instr", g.id, ifid_instr, g.instr);
      chk32("ifid_pc4",   g.id, ifid_pc4,   g.pc4);
      chk32("ifid_valid", g.id, {31'd0, ifid_valid}, {31'd0, g.valid});
   endtask

   vec_t tbl[28];

   initial begin
      rst_n = 1'b0; stall = 1'b0; flush = 1'b0; redirect = 1'b0; redirect_pc = '0;
      //            rst s  f  rd rpc            addr           instr               pc4            v
      tbl[0]  = mk(0, 0, 0, 0, 32'h0,         32'h0,         NOP,                32'h0,         0);
      tbl[1]  = mk(0, 1, 1, 1, 32'h44,        32'h0,         NOP,                32'h0,         0);
      tbl[2]  = mk(1, 0, 0, 0, 32'h0,         32'h4,         mem(32'h0),         32'h4,         1);
      tbl[3]  = mk(1, 0, 0, 0, 32'h0,         32'h8,         mem(32'h4),         32'h8,         1);
      tbl[4]  = mk(1, 1, 0, 0, 32'h0,         32'h8,         mem(32'h4),         32'h8,         1);
      tbl[5]  = mk(1, 1, 0, 0, 32'h0,         32'h8,         mem(32'h4),         32'h8,         1);
      tbl[6]  = mk(1, 1, 0, 0, 32'h0,         32'h8,         mem(32'h4),         32'h8,         1);
      tbl[7]  = mk(1, 0, 0, 0, 32'h0,         32'hC,         mem(32'h8),         32'hC,         1);
      tbl[8]  = mk(1, 0, 0, 1, 32'h23,        32'h20,        NOP,                32'h0,         0);
      tbl[9]  = mk(1, 0, 0, 0, 32'h0,         32'h24,        mem(32'h20),        32'h24,        1);
      tbl[10] = mk(1, 0, 0, 0, 32'h0,         32'h28,        mem(32'h24),        32'h28,        1);
      tbl[11] = mk(1, 1, 0, 1, 32'h40,        32'h28,        mem(32'h24),        32'h28,        1);
      tbl[12] = mk(1, 1, 0, 1, 32'h80,        32'h28,        mem(32'h24),        32'h28,        1);
      tbl[13] = mk(1, 1, 0, 0, 32'h0,         32'h28,        mem(32'h24),        32'h28,        1);
      tbl[14] = mk(1, 0, 0, 0, 32'h0,         32'h80,        NOP,                32'h0,         0);
      tbl[15] = mk(1, 0, 0, 0, 32'h0,         32'h84,        mem(32'h80),        32'h84,        1);
      tbl[16] = mk(1, 1, 1, 0, 32'h0,         32'h84,        NOP,                32'h0,         0);
      tbl[17] = mk(1, 1, 0, 0, 32'h0,         32'h84,        NOP,                32'h0,         0);
      tbl[18] = mk(1, 0, 0, 0, 32'h0,         32'h88,        mem(32'h84),        32'h88,        1);
      tbl[19] = mk(1, 0, 1, 0, 32'h0,         32'h8C,        NOP,                32'h0,         0);
      tbl[20] = mk(1, 0, 1, 1, 32'h101,       32'h100,       NOP,                32'h0,         0);
      tbl[21] = mk(1, 0, 0, 0, 32'h0,         32'h104,       mem(32'h100),       32'h104,       1);
      tbl[22] = mk(1, 1, 0, 1, 32'h200,       32'h104,       mem(32'h100),       32'h104,       1);
      tbl[23] = mk(0, 1, 0, 0, 32'h0,         32'h0,         NOP,                32'h0,         0);
      tbl[24] = mk(1, 0, 0, 0, 32'h0,         32'h4,         mem(32'h0),         32'h4,         1);
      tbl[25] = mk(1, 0, 0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFC, NOP,                32'h0,         0);
      tbl[26] = mk(1, 0, 0, 0, 32'h0,         32'h0,         mem(32'hFFFF_FFFC), 32'h0,         1);
      tbl[27] = mk(1, 0, 0, 0, 32'h0,         32'h4,         mem(32'h0),         32'h4,         1);

      @(posedge clk);
      #1;
      for (int i = 0; i < 28; i++) begin
         run(tbl[i], i);
      end

      // Long stall with a deferred redirect, then release with a flush:
      // the target must land once, with a single bubble.
      run(mk(1, 1, 0, 1, 32'h303, 32'h4, mem(32'h0), 32'h4, 1), 100);
      for (int k = 0; k < 4; k++) begin
         run(mk(1, 1, 0, 0, 32'h0, 32'h4, mem(32'h0), 32'h4, 1), 101 + k);
      end
      run(mk(1, 0, 1, 0, 32'h0, 32'h300, NOP, 32'h0, 0), 105);
      run(mk(1, 0, 0, 0, 32'h0, 32'h304, mem(32'h300), 32'h304, 1), 106);
      run(mk(1, 0, 0, 0, 32'h0, 32'h308, mem(32'h304), 32'h308, 1), 107);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
